// File: rtl/valtrain_detector.sv
// valtrain_detector: valid-lane training pattern detector.
// Counts qualified receive words over a fixed window and reports pass when a
// run of CONSEC_THRESHOLD consecutive PATTERN words was seen in that window.
// Optional build macro VALTRAIN_DET_ERRCNT_EN compiles in the 8-bit saturating
// mismatch counter; without it o_err_count is tied to zero.
module valtrain_detector #(
    parameter int unsigned WINDOW           = 128,
    parameter int unsigned CONSEC_THRESHOLD = 16,
    parameter logic [31:0] PATTERN          = 32'hF0F0F0F0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic [31:0] i_rvld_l,
    input  logic        i_rvld_valid,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic [7:0]  o_err_count
);

    localparam int unsigned      CNT_W    = 8;
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] THRESH   = CNT_W'(CONSEC_THRESHOLD);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DETECT = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] w_win_cnt_nxt;
    logic [CNT_W-1:0] r_consec_cnt;
    logic [CNT_W-1:0] w_consec_cnt_nxt;
    logic             r_pass;
    logic             w_pass_nxt;
    logic             w_match;

    assign w_match = (i_rvld_l == PATTERN);

    // State and run counters register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_win_cnt    <= '0;
            r_consec_cnt <= '0;
            r_pass       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_win_cnt    <= w_win_cnt_nxt;
            r_consec_cnt <= w_consec_cnt_nxt;
            r_pass       <= w_pass_nxt;
        end
    end

    // Next-state and run evaluation; abort on enable drop takes priority
    always_comb begin
        w_state_nxt      = r_state;
        w_win_cnt_nxt    = r_win_cnt;
        w_consec_cnt_nxt = r_consec_cnt;
        w_pass_nxt       = r_pass;
        case (r_state)
            S_IDLE: begin
                if (i_enable) begin
                    w_state_nxt      = S_DETECT;
                    w_win_cnt_nxt    = '0;
                    w_consec_cnt_nxt = '0;
                    w_pass_nxt       = 1'b0;
                end
            end
            S_DETECT: begin
                if (!i_enable) begin
                    w_state_nxt = S_IDLE;
                end else if (i_rvld_valid) begin
                    w_win_cnt_nxt = r_win_cnt + CNT_ONE;
                    if (w_match) begin
                        if (r_consec_cnt != CNT_MAX) begin
                            w_consec_cnt_nxt = r_consec_cnt + CNT_ONE;
                        end
                        if (w_consec_cnt_nxt == THRESH) begin
                            w_pass_nxt = 1'b1;
                        end
                    end else begin
                        w_consec_cnt_nxt = '0;
                    end
                    if (r_win_cnt == WIN_LAST) begin
                        w_state_nxt = S_REPORT;
                    end
                end
            end
            S_REPORT: begin
                if (!i_enable) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Status decoded from registered state only
    assign o_busy = (r_state == S_DETECT);
    assign o_done = (r_state == S_REPORT);
    assign o_pass = (r_state == S_REPORT) && r_pass;

`ifdef VALTRAIN_DET_ERRCNT_EN
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] w_err_cnt_nxt;

    // Saturating mismatch counter, cleared at run start
    always_comb begin
        w_err_cnt_nxt = r_err_cnt;
        if ((r_state == S_IDLE) && i_enable) begin
            w_err_cnt_nxt = '0;
        end else if ((r_state == S_DETECT) && i_enable && i_rvld_valid &&
                     !w_match && (r_err_cnt != CNT_MAX)) begin
            w_err_cnt_nxt = r_err_cnt + CNT_ONE;
        end
    end

    // Error counter register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_cnt <= '0;
        end else begin
            r_err_cnt <= w_err_cnt_nxt;
        end
    end

    assign o_err_count = r_err_cnt;
`else
    assign o_err_count = 8'd0;
`endif

endmodule

// File: tb/tb_valtrain_detector.sv
// Testbench for valtrain_detector: scoreboard of expected run results checked
// by a monitor whenever o_done rises; expectations from a window-level model.
module tb_valtrain_detector;

    localparam logic [31:0] PAT = 32'hF0F0F0F0;
    localparam int          WIN = 128;
    localparam int          THR = 16;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_enable;
    logic [31:0] i_rvld_l;
    logic        i_rvld_valid;
    logic        o_busy;
    logic        o_done;
    logic        o_pass;
    logic [7:0]  o_err_count;

    valtrain_detector dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_enable     (i_enable),
        .i_rvld_l     (i_rvld_l),
        .i_rvld_valid (i_rvld_valid),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_pass       (o_pass),
        .o_err_count  (o_err_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int cyc;
        bit pass;
        int err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] stim_q[$];
    int          n_total = 0;
    int          n_bad   = 0;
    int          cyc     = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int act, int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Window-level reference: longest PATTERN run and mismatch total
    function automatic void model(output bit p, output int e);
        int run = 0;
        int best = 0;
        int mism = 0;
        foreach (stim_q[k]) begin
            if (stim_q[k] == PAT) begin
                run++;
                if (run > best) best = run;
            end else begin
                run = 0;
                mism++;
            end
        end
        p = (best >= THR);
        if (mism > 255) mism = 255;
`ifdef VALTRAIN_DET_ERRCNT_EN
        e = mism;
`else
        e = 0;
`endif
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One run over stim_q; gap_mode 0 none, 1 alternate, 2 random
    task automatic send_run(input int gap_mode, input int abort_at, input int rst_at);
        bit   ep;
        int   ee;
        int   n;
        exp_t x;
        n = stim_q.size();
        model(ep, ee);
        i_enable     = 1'b1;
        i_rvld_valid = 1'b1;
        i_rvld_l     = 32'h1234_5678;
        tick();
        for (int k = 0; k < n; k++) begin
            if (k == abort_at) begin
                i_enable     = 1'b0;
                i_rvld_valid = 1'b0;
                tick();
                chk("abort_busy", int'(o_busy), 0);
                chk("abort_done", int'(o_done), 0);
                tick();
                return;
            end
            if (k == rst_at) begin
                i_rst_n      = 1'b0;
                i_enable     = 1'b0;
                i_rvld_valid = 1'b0;
                #1;
                chk("rst_busy", int'(o_busy), 0);
                chk("rst_done", int'(o_done), 0);
                chk("rst_pass", int'(o_pass), 0);
                chk("rst_err",  int'(o_err_count), 0);
                tick();
                i_rst_n = 1'b1;
                tick();
                chk("post_rst_busy", int'(o_busy), 0);
                return;
            end
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(3) == 0)) begin
                i_rvld_valid = 1'b0;
                i_rvld_l     = (gap_mode == 1) ? 32'h0 : PAT;
                tick();
            end
            i_rvld_valid = 1'b1;
            i_rvld_l     = stim_q[k];
            if (k == n - 1) begin
                x.cyc  = cyc + 1;
                x.pass = ep;
                x.err  = ee;
                sb_q.push_back(x);
            end
            tick();
        end
        // Inputs in REPORT must be ignored
        i_rvld_valid = 1'b1;
        i_rvld_l     = 32'h0;
        repeat (3) tick();
        chk("report_busy", int'(o_busy), 0);
        chk("report_done", int'(o_done), 1);
        i_enable     = 1'b0;
        i_rvld_valid = 1'b0;
        tick();
        chk("release_done", int'(o_done), 0);
        tick();
    endtask

    task automatic fill(input int mode);
        stim_q.delete();
        for (int k = 0; k < WIN; k++) begin
            case (mode)
                0: stim_q.push_back(PAT);
                1: stim_q.push_back(32'h0);
                2: stim_q.push_back((k % 16 == 15) ? 32'h0 : PAT);
                3: stim_q.push_back((k < 16) ? PAT : 32'h0F0F0F0F);
                4: stim_q.push_back((k >= 112) ? PAT : 32'h0F0F0F0F);
                5: stim_q.push_back(($urandom_range(15) == 0) ? $urandom : PAT);
                default: stim_q.push_back(($urandom_range(7) == 0) ? $urandom : PAT);
            endcase
        end
    endtask

    // Monitor: pop on o_done rise, then hold results stable while done
    bit   prev_done = 1'b0;
    exp_t cur;
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            prev_done = 1'b0;
        end else begin
            chk("busy_done_excl", int'(o_busy & o_done), 0);
            if (o_done && !prev_done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", int'(o_done), 0);
                end else begin
                    cur = sb_q.pop_front();
                    chk("done_latency", cyc, cur.cyc);
                    chk("pass", int'(o_pass), int'(cur.pass));
                    chk("err_count", int'(o_err_count), cur.err);
                end
            end else if (o_done) begin
                chk("hold_pass", int'(o_pass), int'(cur.pass));
                chk("hold_err", int'(o_err_count), cur.err);
            end else begin
                chk("pass_without_done", int'(o_pass), 0);
            end
            prev_done = o_done;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n      = 1'b0;
        i_enable     = 1'b0;
        i_rvld_valid = 1'b0;
        i_rvld_l     = 32'h0;
        #1;
        chk("reset_busy", int'(o_busy), 0);
        chk("reset_done", int'(o_done), 0);
        chk("reset_pass", int'(o_pass), 0);
        chk("reset_err",  int'(o_err_count), 0);
        repeat (2) tick();
        i_rst_n = 1'b1;
        tick();

        fill(0); send_run(0, -1, -1);
        fill(1); send_run(0, -1, -1);
        fill(2); send_run(0, -1, -1);
        fill(3); send_run(0, -1, -1);
        fill(4); send_run(0, -1, -1);
        fill(0); send_run(1, -1, -1);
        fill(1); send_run(0, 50, -1);
        fill(4); send_run(0, -1, -1);
        fill(0); send_run(0, -1, 60);
        fill(3); send_run(2, -1, -1);
        for (int r = 0; r < 6; r++) begin
            fill(5 + (r % 2));
            send_run(2, -1, -1);
        end

        repeat (3) tick();
        chk("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/valtrain_detector.md
VALTRAIN_DETECTOR -- requirements
Module: valtrain_detector

Interface
REQ-001 Parameter WINDOW, default 128, meaning the number of qualified receive words evaluated per detection run (legal range 1..255).
REQ-002 Parameter CONSEC_THRESHOLD, default 16, meaning the number of consecutive matching words required for pass (legal range 1..WINDOW).
REQ-003 Parameter PATTERN, default 32'hF0F0F0F0, meaning the expected valid-lane word.
REQ-004 i_clk  input  1  clock; all state is updated on the rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_enable  input  1  level-sensitive detection request from the training sequencer.
REQ-007 i_rvld_l  input  32  deserialized receive valid-lane word.
REQ-008 i_rvld_valid  input  1  qualifier; i_rvld_l is sampled only when this is 1.
REQ-009 o_busy  output  1  1 while in DETECT.
REQ-010 o_done  output  1  1 while in REPORT.
REQ-011 o_pass  output  1  detection result; meaningful only while o_done=1, otherwise 0.
REQ-012 o_err_count  output  8  count of mismatching qualified words in the current or last run.

Function
REQ-013 The FSM SHALL have three states: IDLE, DETECT and REPORT, all registered, with no other reachable states.
- Unused encodings SHALL return to IDLE.
REQ-014 IDLE SHALL move to DETECT on the first clock edge where i_enable=1.
- On that edge, the window counter, consecutive counter, pass flag and error count SHALL be cleared.
REQ-015 In DETECT, each qualified word SHALL increment the window counter.
- Unqualified cycles SHALL leave all counters unchanged.
REQ-016 A qualified word equal to PATTERN (exact 32-bit compare) SHALL increment the consecutive counter, saturating at 255.
REQ-017 A qualified word not equal to PATTERN SHALL clear the consecutive counter and increment the error count, saturating at 255.
REQ-018 The sticky pass flag SHALL set on the edge at which the consecutive counter reaches CONSEC_THRESHOLD, and SHALL never clear within the run.
REQ-019 On the qualified word that brings the window counter to WINDOW, the FSM SHALL move to REPORT.
- That word's match/mismatch SHALL be included in pass and error evaluation.
- o_done SHALL therefore assert on the cycle after the last word is sampled.
REQ-020 REPORT SHALL hold o_done=1, o_pass and o_err_count stable while i_enable=1.
- When i_enable=0, the FSM SHALL return to IDLE on the next edge.
REQ-021 If i_enable=0 while in DETECT, the FSM SHALL abort to IDLE on the next edge.
- o_done SHALL not assert and the partial results SHALL be discarded (o_pass=0).
REQ-022 i_rvld_l and i_rvld_valid SHALL be ignored in IDLE and REPORT.
REQ-023 o_busy, o_done and o_pass SHALL be decoded from registered state only, with no combinational path from any input.

Reset
REQ-024 While i_rst_n=0, the FSM and all outputs SHALL take these values regardless of i_clk:
- state = IDLE
- o_busy = 0, o_done = 0, o_pass = 0, o_err_count = 0
REQ-025 Reset asserted mid-run SHALL abort the run with no result reported.
- After release, the block SHALL wait in IDLE for i_enable.

Configuration
REQ-026 Macro VALTRAIN_DET_ERRCNT_EN selects whether error counting is compiled in.
- Defined: the 8-bit saturating error counter SHALL be implemented and driven onto o_err_count.
- Undefined: no error counter register SHALL exist and o_err_count SHALL be tied to 0.
- Pass/fail behaviour SHALL be identical in both builds.

Verification
REQ-027 128 consecutive qualified 32'hF0F0F0F0 words -> o_done=1 one cycle after word 128, o_pass=1, o_err_count=0.
REQ-028 128 qualified 32'h00000000 words -> o_done=1, o_pass=0, o_err_count=128 (0 when VALTRAIN_DET_ERRCNT_EN is undefined).
REQ-029 Repeating sequence of 15 pattern words then 1 mismatch, over 128 words -> o_pass=0, o_err_count=8.
REQ-030 Windowed runs with the default CONSEC_THRESHOLD of 16:
- 16 pattern words then 112 x 32'h0F0F0F0F -> o_pass=1, o_err_count=112.
- 112 x 32'h0F0F0F0F then 16 pattern words -> o_pass=1, showing that the last word counts.
REQ-031 i_rvld_valid deasserted on every other cycle during a clean run -> o_done asserts only after 128 qualified words (about 256 cycles), with o_pass=1.
REQ-032 Abort and reset mid-run:
- i_enable dropped after 50 words -> IDLE next edge, o_done never asserts.
- Re-enable -> a fresh run with cleared counters.
- Reset pulse at word 60 -> all outputs 0 immediately.
